// File: rtl/tt_um_unload_pkg.sv
// Shared definitions for the weight readback serializer.
//   state_t   : controller states (CKSUM exists only with TT_UM_UNLOAD_CKSUM_EN)
//   nchunk    : number of data beats for a given weight width and neuron count
//   cnt_width : bits needed to count 0..n inclusive
package tt_um_unload_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
`ifdef TT_UM_UNLOAD_CKSUM_EN
        CKSUM = 2'd2,
`endif
        FIN   = 2'd3
    } state_t;

    // One MAX_IN_LEN-bit chunk per (weight bit, neuron) pair.
    function automatic int nchunk(input int width, input int max_out_len);
        return width * max_out_len;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tt_um_unload_shadow.sv
// Snapshot-and-shift register for the readback serializer.
//   clk, rst  : clock, synchronous active-high reset (clears contents)
//   load      : capture din into the register
//   shift     : move every chunk one slot towards the top, zero fill at the bottom
//   din       : packed weight array, TOTAL_W bits
//   top_chunk : the most significant CHUNK_W bits currently held
// load has priority over shift.
module tt_um_unload_shadow #(
    parameter int TOTAL_W = 144,
    parameter int CHUNK_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic [TOTAL_W-1:0] din,
    output logic [CHUNK_W-1:0] top_chunk
);

    localparam int NCH = TOTAL_W / CHUNK_W;

    // Slot 0 holds the most significant chunk, slot NCH-1 the least.
    logic [CHUNK_W-1:0] chunk_reg   [NCH];
    logic [CHUNK_W-1:0] load_slice  [NCH];
    logic [CHUNK_W-1:0] shift_slice [NCH];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_slot
            assign load_slice[gi] = din[TOTAL_W - 1 - gi*CHUNK_W -: CHUNK_W];
            if (gi < NCH - 1) begin : g_mid
                assign shift_slice[gi] = chunk_reg[gi + 1];
            end else begin : g_last
                assign shift_slice[gi] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                chunk_reg[i] <= '0;
            end
        end else if (load) begin
            chunk_reg <= load_slice;
        end else if (shift) begin
            chunk_reg <= shift_slice;
        end
    end

    assign top_chunk = chunk_reg[0];

endmodule

// File: rtl/tt_um_unload.sv
// Weight readback serializer: snapshots the packed ternary weight array on
// start and streams it out MSB chunk first, one MAX_IN_LEN-bit beat per
// valid/ready transfer, so the beats can be fed straight back into the loader.
//   clk, rst   : clock, synchronous active-high reset (aborts any stream)
//   ena        : block enable; low freezes all state and drops out_valid
//   start      : readback request, only honoured in IDLE
//   weights_in : packed weight array (WIDTH*MAX_IN_LEN*MAX_OUT_LEN bits)
//   out_data   : current beat; out_valid/out_ready handshake
//   busy       : readback in progress (SEND/CKSUM/FIN)
//   done       : one-cycle pulse after the final beat is accepted
// Build option TT_UM_UNLOAD_CKSUM_EN appends one extra beat holding the XOR of
// all data chunks.
module tt_um_unload
    import tt_um_unload_pkg::*;
#(
    parameter int MAX_IN_LEN  = 12,
    parameter int MAX_OUT_LEN = 6,
    parameter int WIDTH       = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    ena,
    input  logic                                    start,
    input  logic [WIDTH*MAX_IN_LEN*MAX_OUT_LEN-1:0] weights_in,
    output logic [MAX_IN_LEN-1:0]                   out_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic                                    busy,
    output logic                                    done
);

    localparam int NCHUNK  = nchunk(WIDTH, MAX_OUT_LEN);
    localparam int CNT_W   = cnt_width(NCHUNK);
    localparam int TOTAL_W = WIDTH * MAX_IN_LEN * MAX_OUT_LEN;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        count_reg, count_next;
    logic                    load_en;
    logic                    shift_en;
    logic [MAX_IN_LEN-1:0]   top_chunk;
`ifdef TT_UM_UNLOAD_CKSUM_EN
    logic [MAX_IN_LEN-1:0]   cksum_reg, cksum_next;
`endif

    tt_um_unload_shadow #(
        .TOTAL_W (TOTAL_W),
        .CHUNK_W (MAX_IN_LEN)
    ) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .load      (load_en),
        .shift     (shift_en),
        .din       (weights_in),
        .top_chunk (top_chunk)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
`ifdef TT_UM_UNLOAD_CKSUM_EN
            cksum_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
`ifdef TT_UM_UNLOAD_CKSUM_EN
            cksum_reg <= cksum_next;
`endif
        end
    end

    // out_valid already folds in ena, so "out_valid && out_ready" is the
    // complete transfer condition in both beat-carrying states.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        load_en    = 1'b0;
        shift_en   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        out_data   = top_chunk;
`ifdef TT_UM_UNLOAD_CKSUM_EN
        cksum_next = cksum_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start && ena) begin
                    load_en    = 1'b1;
                    count_next = '0;
`ifdef TT_UM_UNLOAD_CKSUM_EN
                    cksum_next = '0;
`endif
                    state_next = SEND;
                end
            end
            SEND: begin
                busy      = 1'b1;
                out_valid = ena;
                if (ena && out_ready) begin
                    shift_en   = 1'b1;
                    count_next = count_reg + CNT_W'(1);
`ifdef TT_UM_UNLOAD_CKSUM_EN
                    cksum_next = cksum_reg ^ top_chunk;
`endif
                    if (count_reg == CNT_W'(NCHUNK - 1)) begin
`ifdef TT_UM_UNLOAD_CKSUM_EN
                        state_next = CKSUM;
`else
                        state_next = FIN;
`endif
                    end
                end
            end
`ifdef TT_UM_UNLOAD_CKSUM_EN
            CKSUM: begin
                busy      = 1'b1;
                out_valid = ena;
                out_data  = cksum_reg;
                if (ena && out_ready) begin
                    state_next = FIN;
                end
            end
`endif
            FIN: begin
                // Held (with done low) while stalled so the pulse is still
                // exactly one enabled cycle long.
                busy = 1'b1;
                done = ena;
                if (ena) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tt_um_unload.sv
// Self-checking bench for tt_um_unload. Inputs change 1ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_tt_um_unload;

    localparam int MIL = 12;
    localparam int MOL = 6;
    localparam int WID = 2;
    localparam int NCH = WID * MOL;
    localparam int TW  = WID * MIL * MOL;
`ifdef TT_UM_UNLOAD_CKSUM_EN
    localparam int NB  = NCH + 1;
`else
    localparam int NB  = NCH;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           ena;
    logic           start;
    logic [TW-1:0]  weights_in;
    logic [MIL-1:0] out_data;
    logic           out_valid;
    logic           out_ready;
    logic           busy;
    logic           done;

    int total = 0;
    int bad   = 0;

    logic [MIL-1:0] exp_q[$];
    logic [MIL-1:0] got_q[$];
    bit             done_seen;
    int             done_cnt;

    tt_um_unload #(
        .MAX_IN_LEN  (MIL),
        .MAX_OUT_LEN (MOL),
        .WIDTH       (WID)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .start      (start),
        .weights_in (weights_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: beat k is the k-th chunk counted from the MSB end; the
    // optional trailing beat is the XOR of every chunk.
    task automatic build_expected(input logic [TW-1:0] w);
        logic [TW-1:0]  v;
        logic [MIL-1:0] x;
        exp_q.delete();
        x = '0;
        for (int k = 0; k < NCH; k++) begin
            v = w >> ((NCH - 1 - k) * MIL);
            exp_q.push_back(v[MIL-1:0]);
            x = x ^ v[MIL-1:0];
        end
`ifdef TT_UM_UNLOAD_CKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    function automatic logic [TW-1:0] pattern_w();
        logic [TW-1:0] w;
        w = '0;
        for (int k = 0; k < NCH; k++) begin
            w = (w << MIL) | TW'(k + 1);
        end
        return w;
    endfunction

    function automatic logic [TW-1:0] random_w();
        logic [TW-1:0] w;
        w = '0;
        for (int i = 0; i < (TW + 31) / 32; i++) begin
            w = (w << 32) | TW'($urandom());
        end
        return w;
    endfunction

    task automatic start_stream(input logic [TW-1:0] w);
        ena        = 1'b1;
        weights_in = w;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Runs cycles until done is seen or the budget expires; records beats.
    task automatic run_stream(input bit rand_ready, input bit rand_ena);
        got_q.delete();
        done_seen = 1'b0;
        done_cnt  = 0;
        for (int c = 0; c < 400 && !done_seen; c++) begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            ena       = rand_ena   ? ($urandom_range(0, 4) != 0) : 1'b1;
            @(negedge clk);
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (done) begin
                done_seen = 1'b1;
                done_cnt++;
            end
            tick();
        end
        ena       = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=000", out_data); end
        tick();
        rst = 1'b0;
        $display("txn reset: valid=%b busy=%b done=%b", out_valid, busy, done);
    endtask

    task automatic test_pattern();
        logic [MIL-1:0] e;
        out_ready = 1'b1;
        start_stream(pattern_w());
        for (int k = 0; k < NB; k++) begin
            e = (k < NCH) ? MIL'(k + 1) : 12'h00C;
            @(negedge clk);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pat_valid k=%0d got=%b exp=1", k, out_valid); end
            total++; if (out_data !== e) begin bad++; $display("FAIL pat_data k=%0d got=%h exp=%h", k, out_data, e); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL pat_early_done k=%0d got=%b exp=0", k, done); end
            $display("txn pattern beat %0d: data=%h", k, out_data);
            tick();
        end
        @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL pat_done got=%b exp=1", done); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pat_fin_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL pat_fin_busy got=%b exp=1", busy); end
        tick();
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL pat_done_len got=%b exp=0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL pat_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_backpressure();
        logic [TW-1:0] w;
        w = pattern_w();
        build_expected(w);
        out_ready = 1'b1;
        start_stream(w);
        got_q.delete();
        done_seen = 1'b0;
        for (int c = 0; c < 60 && !done_seen; c++) begin
            out_ready = !(c >= 1 && c <= 3);
            @(negedge clk);
            if (c >= 1 && c <= 3) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid c=%0d got=%b exp=1", c, out_valid); end
                total++; if (out_data !== 12'h002) begin bad++; $display("FAIL bp_hold_data c=%0d got=%h exp=002", c, out_data); end
            end
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (done) done_seen = 1'b1;
            tick();
        end
        out_ready = 1'b1;
        total++; if (done_seen !== 1'b1) begin bad++; $display("FAIL bp_done_timeout got=%b exp=1", done_seen); end
        total++; if (got_q.size() != NB) begin bad++; $display("FAIL bp_beats got=%0d exp=%0d", got_q.size(), NB); end
        for (int k = 0; k < NB && k < got_q.size(); k++) begin
            total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL bp_data k=%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
        $display("txn backpressure: beats=%0d done=%b", got_q.size(), done_seen);
    endtask

    task automatic test_stall_snapshot();
        logic [TW-1:0] w;
        w = random_w();
        build_expected(w);
        out_ready = 1'b1;
        start_stream(w);
        weights_in = ~w;
        got_q.delete();
        done_seen = 1'b0;
        for (int c = 0; c < 60 && !done_seen; c++) begin
            ena = !(c == 3 || c == 4);
            @(negedge clk);
            if (c == 3 || c == 4) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_valid c=%0d got=%b exp=0", c, out_valid); end
                total++; if (out_data !== exp_q[3]) begin bad++; $display("FAIL stall_hold c=%0d got=%h exp=%h", c, out_data, exp_q[3]); end
            end
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (done) done_seen = 1'b1;
            tick();
        end
        ena = 1'b1;
        total++; if (done_seen !== 1'b1) begin bad++; $display("FAIL stall_done_timeout got=%b exp=1", done_seen); end
        total++; if (got_q.size() != NB) begin bad++; $display("FAIL stall_beats got=%0d exp=%0d", got_q.size(), NB); end
        for (int k = 0; k < NB && k < got_q.size(); k++) begin
            total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL stall_data k=%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
        $display("txn stall/snapshot: beats=%0d done=%b", got_q.size(), done_seen);
    endtask

    task automatic test_reset_mid();
        int dcount;
        out_ready = 1'b1;
        start_stream(pattern_w());
        for (int c = 0; c < 4; c++) tick();
        @(negedge clk);
        total++; if (out_data !== 12'h005) begin bad++; $display("FAIL rstmid_beat got=%h exp=005", out_data); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        dcount = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (done || busy) dcount++;
            tick();
        end
        total++; if (dcount != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", dcount); end
        $display("txn reset mid-stream: busy=%b valid=%b", busy, out_valid);
    endtask

    task automatic test_start_rules();
        logic [TW-1:0] w1;
        logic [TW-1:0] w2;
        w1 = random_w();
        w2 = random_w();
        build_expected(w1);
        out_ready = 1'b1;
        start_stream(w1);
        got_q.delete();
        done_seen = 1'b0;
        for (int c = 0; c < 60 && !done_seen; c++) begin
            start      = (c == 5);
            weights_in = (c >= 5) ? w2 : w1;
            @(negedge clk);
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (done) begin
                done_seen = 1'b1;
                start     = 1'b1;   // coincides with done: must be ignored
            end
            tick();
        end
        start = 1'b0;
        @(negedge clk);
        total++; if (done_seen !== 1'b1) begin bad++; $display("FAIL srule_done_timeout got=%b exp=1", done_seen); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL srule_start_at_done got=%b exp=0", busy); end
        total++; if (got_q.size() != NB) begin bad++; $display("FAIL srule_beats got=%0d exp=%0d", got_q.size(), NB); end
        for (int k = 0; k < NB && k < got_q.size(); k++) begin
            total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL srule_data k=%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
        build_expected(w2);
        tick();
        start_stream(w2);
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL srule_restart_busy got=%b exp=1", busy); end
        total++; if (out_data !== exp_q[0]) begin bad++; $display("FAIL srule_restart_data got=%h exp=%h", out_data, exp_q[0]); end
        tick();
        run_stream(1'b0, 1'b0);
        total++; if (done_seen !== 1'b1) begin bad++; $display("FAIL srule_drain_timeout got=%b exp=1", done_seen); end
        $display("txn start rules: first_stream_beats=%0d", NB);
    endtask

    task automatic test_roundtrip();
        logic [TW-1:0]  w;
        logic [TW-1:0]  acc;
        for (int it = 0; it < 20; it++) begin
            w = random_w();
            build_expected(w);
            start_stream(w);
            run_stream(1'b1, 1'b1);
            acc = '0;
            for (int k = 0; k < NCH && k < got_q.size(); k++) begin
                acc = (acc << MIL) | TW'(got_q[k]);
            end
            total++; if (done_seen !== 1'b1) begin bad++; $display("FAIL rt_done_timeout it=%0d got=%b exp=1", it, done_seen); end
            total++; if (got_q.size() != NB) begin bad++; $display("FAIL rt_beats it=%0d got=%0d exp=%0d", it, got_q.size(), NB); end
            total++; if (acc !== w) begin bad++; $display("FAIL rt_loader it=%0d got=%h exp=%h", it, acc, w); end
`ifdef TT_UM_UNLOAD_CKSUM_EN
            if (got_q.size() == NB) begin
                total++; if (got_q[NCH] !== exp_q[NCH]) begin bad++; $display("FAIL rt_cksum it=%0d got=%h exp=%h", it, got_q[NCH], exp_q[NCH]); end
            end
`endif
            $display("txn roundtrip %0d: beats=%0d match=%b", it, got_q.size(), acc === w);
            tick();
        end
    endtask

    initial begin
        rst        = 1'b1;
        ena        = 1'b1;
        start      = 1'b0;
        out_ready  = 1'b1;
        weights_in = '0;
        test_reset();
        test_pattern();
        test_backpressure();
        test_stall_snapshot();
        test_reset_mid();
        test_start_rules();
        test_roundtrip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
